// File: rtl/tpu_instruction_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tpu_instruction_dispatch
// Purpose  : Takes instructions from the instruction FIFO, decodes the
//            op_code, waits out structural/data hazards against the
//            weight-load, matrix-multiply and activation units, then issues
//            each instruction to exactly one unit as a one-cycle enable
//            pulse. Also handles NOP, HALT and malformed instructions.
// Ports    : clk, rst (sync, active-high), enable (global stall)
//            in_valid/in_ready + in_* fields : instruction FIFO handshake
//            out_*                           : held instruction, shared bus
//            *_instr_en                      : one-cycle issue pulses
//            *_busy, mm_resource_busy        : unit status
//            halted, decode_error            : sticky halt / error pulse
//            *_issued_cnt                    : wrapping issue counters
// Revision : 1.0 - initial release
// ============================================================================
module tpu_instruction_dispatch #(
  parameter int OP_CODE_WIDTH  = 8,
  parameter int LENGTH_WIDTH   = 32,
  parameter int ACC_ADDR_WIDTH = 16,
  parameter int BUF_ADDR_WIDTH = 24,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_CODE_WIDTH-1:0]  in_op_code,
  input  logic [LENGTH_WIDTH-1:0]   in_calc_length,
  input  logic [ACC_ADDR_WIDTH-1:0] in_acc_address,
  input  logic [BUF_ADDR_WIDTH-1:0] in_buffer_address,
  output logic [OP_CODE_WIDTH-1:0]  out_op_code,
  output logic [LENGTH_WIDTH-1:0]   out_calc_length,
  output logic [ACC_ADDR_WIDTH-1:0] out_acc_address,
  output logic [BUF_ADDR_WIDTH-1:0] out_buffer_address,
  output logic                      weight_instr_en,
  output logic                      mm_instr_en,
  output logic                      act_instr_en,
  input  logic                      weight_busy,
  input  logic                      mm_busy,
  input  logic                      mm_resource_busy,
  input  logic                      act_busy,
  output logic                      halted,
  output logic                      decode_error,
  output logic [CNT_WIDTH-1:0]      mm_issued_cnt,
  output logic [CNT_WIDTH-1:0]      weight_issued_cnt,
  output logic [CNT_WIDTH-1:0]      act_issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_NOP    = 3'd0,
    K_HALT   = 3'd1,
    K_WEIGHT = 3'd2,
    K_MM     = 3'd3,
    K_ACT    = 3'd4,
    K_ILL    = 3'd5
  } kind_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [OP_CODE_WIDTH-1:0]    r_op;
  logic [LENGTH_WIDTH-1:0]     r_len;
  logic [ACC_ADDR_WIDTH-1:0]   r_acc;
  logic [BUF_ADDR_WIDTH-1:0]   r_buf;
  logic                        r_wg, r_mg, r_ag;
  logic [CNT_WIDTH-1:0]        r_w_cnt, r_mm_cnt, r_act_cnt;

  kind_t                       w_kind;
  logic                        w_illegal;
  logic                        w_accept;
  logic                        w_w_en, w_mm_en, w_act_en;
  logic                        w_dec_err;

  // Decode always works on the held copy so CHECK and ISSUE see a stable
  // instruction regardless of what the FIFO presents meanwhile.
  always_comb begin
    w_kind = K_ILL;
    if (r_op[7:0] == 8'h00)          w_kind = K_NOP;
    else if (r_op[7:0] == 8'hFF)     w_kind = K_HALT;
    else if (r_op[7:3] == 5'b00001)  w_kind = K_WEIGHT;
    else if (r_op[7:3] == 5'b00100)  w_kind = K_MM;
    else if (r_op[7])                w_kind = K_ACT;
    w_illegal = (w_kind == K_ILL) ||
                (((w_kind == K_WEIGHT) || (w_kind == K_MM) || (w_kind == K_ACT)) &&
                 (r_len == '0));
  end

  // Next state and the combinational pulses; nothing advances while enable=0.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_w_en      = 1'b0;
    w_mm_en     = 1'b0;
    w_act_en    = 1'b0;
    w_dec_err   = 1'b0;
    if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_illegal) begin
            w_dec_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            case (w_kind)
              K_NOP:    w_state_nxt = S_IDLE;
              K_HALT:   if (!mm_busy && !mm_resource_busy && !weight_busy && !act_busy &&
                            !r_wg && !r_mg && !r_ag)
                          w_state_nxt = S_HALTED;
              K_WEIGHT: if (!weight_busy && !r_wg)
                          w_state_nxt = S_ISSUE;
              // MATMUL consumes the weights, so it also waits on the loader.
              K_MM:     if (!mm_busy && !r_mg && !weight_busy && !r_wg)
                          w_state_nxt = S_ISSUE;
              // ACTIVATE reads accumulators the matmul may still be writing.
              K_ACT:    if (!act_busy && !r_ag && !mm_resource_busy && !r_mg)
                          w_state_nxt = S_ISSUE;
              default:  w_state_nxt = S_IDLE;
            endcase
          end
        end
        S_ISSUE: begin
          w_w_en      = (w_kind == K_WEIGHT);
          w_mm_en     = (w_kind == K_MM);
          w_act_en    = (w_kind == K_ACT);
          w_state_nxt = S_IDLE;
        end
        S_HALTED: w_state_nxt = S_HALTED;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_len     <= '0;
      r_acc     <= '0;
      r_buf     <= '0;
      r_wg      <= 1'b0;
      r_mg      <= 1'b0;
      r_ag      <= 1'b0;
      r_w_cnt   <= '0;
      r_mm_cnt  <= '0;
      r_act_cnt <= '0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= in_op_code;
        r_len <= in_calc_length;
        r_acc <= in_acc_address;
        r_buf <= in_buffer_address;
      end
      // Guard is high for exactly the enabled cycle after an issue, bridging
      // the unit's one-cycle delay before its busy asserts.
      r_wg <= w_w_en;
      r_mg <= w_mm_en;
      r_ag <= w_act_en;
      if (w_w_en)   r_w_cnt   <= r_w_cnt + c_cnt_one;
      if (w_mm_en)  r_mm_cnt  <= r_mm_cnt + c_cnt_one;
      if (w_act_en) r_act_cnt <= r_act_cnt + c_cnt_one;
    end
  end

  assign in_ready           = (r_state == S_IDLE) && enable;
  assign out_op_code        = r_op;
  assign out_calc_length    = r_len;
  assign out_acc_address    = r_acc;
  assign out_buffer_address = r_buf;
  assign weight_instr_en    = w_w_en;
  assign mm_instr_en        = w_mm_en;
  assign act_instr_en       = w_act_en;
  assign decode_error       = w_dec_err;
  assign halted             = (r_state == S_HALTED);
  assign mm_issued_cnt      = r_mm_cnt;
  assign weight_issued_cnt  = r_w_cnt;
  assign act_issued_cnt     = r_act_cnt;

endmodule
`default_nettype wire

// File: doc/tpu_instruction_dispatch.md
Name: tpu_instruction_dispatch

Overview:
- Sits directly upstream of the matrix-multiply, weight-load and activation control units.
- Accepts instructions from the instruction FIFO over a valid/ready handshake and decodes the op_code.
- Checks structural and data hazards against each unit's busy / resource_busy.
- Issues each instruction as a one-cycle enable pulse, with the instruction fields held stable, to exactly one unit. Also handles NOP, HALT and malformed instructions.

Parameters:
- OP_CODE_WIDTH, 8, instruction op_code width
- LENGTH_WIDTH, 32, calc_length width
- ACC_ADDR_WIDTH, 16, accumulator address width
- BUF_ADDR_WIDTH, 24, unified buffer address width
- CNT_WIDTH, 16, width of each issued-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  global stall; when 0, all state and counters hold and no handshake or issue occurs
- in_valid  in  1  FIFO has an instruction
- in_ready  out  1  dispatcher accepts this cycle
- in_op_code  in  OP_CODE_WIDTH  op_code
- in_calc_length  in  LENGTH_WIDTH  calc_length
- in_acc_address  in  ACC_ADDR_WIDTH  acc_address
- in_buffer_address  in  BUF_ADDR_WIDTH  buffer_address
- out_op_code / out_calc_length / out_acc_address / out_buffer_address  out  (same widths)  registered instruction, shared by all units
- weight_instr_en / mm_instr_en / act_instr_en  out  1  one-cycle issue pulses
- weight_busy, mm_busy, mm_resource_busy, act_busy  in  1  unit status
- halted  out  1  sticky HALT reached
- decode_error  out  1  one-cycle pulse on an illegal instruction
- mm_issued_cnt, weight_issued_cnt, act_issued_cnt  out  CNT_WIDTH  issue counters, wrap at 2^CNT_WIDTH

Behaviour:
- Reset values: all outputs 0, except in_ready, which is 1 from the first cycle after reset. State = IDLE and every guard flag is cleared.
- Decode:
  - NOP = 8'h00
  - HALT = 8'hFF
  - LOAD_WEIGHT = op[7:3]==5'b00001
  - MATMUL = op[7:3]==5'b00100, with op[1] = accumulate and op[0] = signed, passed through unchanged
  - ACTIVATE = op[7]==1 and op != 8'hFF
  - Anything else is illegal.
  - calc_length==0 on LOAD_WEIGHT, MATMUL or ACTIVATE is also illegal.
- State machine:
  - IDLE: in_ready=1. On in_valid && enable, latch all fields into the out_* registers and go to CHECK.
  - CHECK: in_ready=0.
    - NOP: go to IDLE.
    - Illegal: pulse decode_error for 1 cycle, drop the instruction, go to IDLE.
    - HALT: go to HALTED once mm_busy, mm_resource_busy, weight_busy and act_busy are all 0 and no guard flag is set. Otherwise stay in CHECK.
    - Unit instruction: go to ISSUE when its condition holds, otherwise stay in CHECK (stall):
      - LOAD_WEIGHT: !weight_busy && !wg
      - MATMUL: !mm_busy && !mg && !weight_busy && !wg
      - ACTIVATE: !act_busy && !ag && !mm_resource_busy && !mg
  - ISSUE: the matching *_instr_en is 1 for exactly this cycle. Set that unit's guard flag (wg/mg/ag), increment its counter, go to IDLE. out_* hold their values until the next accept.
  - HALTED: halted=1, in_ready=0. Only rst leaves this state.
- Guard flags:
  - A flag is set in ISSUE and cleared at the end of the following cycle. It covers the unit's one-cycle busy-assert latency.
  - Because the flag is sampled, an issue to the same unit cannot occur earlier than 3 cycles after the previous issue, even with busy=0.
- Latency: accept at edge N → *_instr_en high in cycle N+2 when no stall. Peak throughput is 1 instruction per 3 cycles.
- Simultaneous events: a busy deasserting in the same cycle as CHECK is honoured in that cycle (combinational check of the sampled inputs).
- enable=0 in any state freezes the state, flags and counters. An *_instr_en pulse is issued only when enable=1; ISSUE waits for enable.
- rst mid-operation returns to IDLE and drops the held instruction, with no issue pulse.
- Counter wrap: 16'hFFFF + 1 → 16'h0000, no flag.

Test Plan:
- Reset, then MATMUL op=8'h23, len=14, acc=0x10, buf=0x100, all busies 0 → mm_instr_en high exactly 2 cycles after accept; out_op_code=8'h23, out_calc_length=14; mm_issued_cnt=1.
- LOAD_WEIGHT (8'h08, len=14) issued, weight_busy=1 for 20 cycles; then MATMUL offered → MATMUL stalls in CHECK, in_ready=0. mm_instr_en asserts in the cycle after CHECK sees weight_busy fall and wg clear.
- ACTIVATE (8'h81, len=4) while mm_resource_busy=1 for 19 cycles → no act_instr_en until mm_resource_busy=0; then a single pulse.
- Op 8'h50, then MATMUL with len=0 → two decode_error pulses, no *_instr_en, counters unchanged.
- HALT with act_busy=1 for 5 cycles → halted rises after act_busy falls; further in_valid is ignored (in_ready=0); rst clears halted.
- Two back-to-back MATMULs with busy held 0 → issues spaced exactly 3 cycles apart. rst asserted during the second CHECK → no second pulse, mm_issued_cnt=0 after reset.
